// File: rtl/fnd_pkg.sv
// Shared types, segment constants and helpers for the FND scan controller.
// Segment bytes are active-low {dp,g,f,e,d,c,b,a}.
package fnd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } conv_state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    // Active-low segment pattern for one hex nibble, decimal point off.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

    // 10^n, used to size the overflow threshold at elaboration time.
    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/fnd_scan_controller_bin2bcd.sv
// fnd_bin2bcd_seq: sequential shift-add-3 binary to BCD converter.
// One start pulse in IDLE runs DATA_W shift cycles, then a single COMMIT
// cycle where done_o is high and bcd_o/ovf_o hold the finished result.
module fnd_bin2bcd_seq
    import fnd_pkg::*;
#(
    parameter int DATA_W     = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_i,
    input  logic [DATA_W-1:0]       data_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [4*NUM_DIGITS-1:0] bcd_o,
    output logic                    ovf_o
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam longint unsigned OVF_LIMIT = pow10(NUM_DIGITS);

    conv_state_t        state_q;
    logic [DATA_W-1:0]  bin_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [BCD_W-1:0]   bcd_adj;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_q;
    logic               busy_q;

    // Add 3 to every nibble that would reach 10 or more after the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Converter FSM: load on start, shift DATA_W times, present result for one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        bin_q   <= data_i;
                        bcd_q   <= '0;
                        cnt_q   <= CNT_W'(DATA_W);
                        ovf_q   <= ({{(64-DATA_W){1'b0}}, data_i} >= OVF_LIMIT);
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_q <= {bcd_adj[BCD_W-2:0], bin_q[DATA_W-1]};
                    bin_q <= bin_q << 1;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = (state_q == COMMIT);
    assign bcd_o  = bcd_q;
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller: binary value to multiplexed common-anode FND display.
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the most
// significant nonzero digit (digit 0 always shown, dashes never blanked).
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int SCAN_HZ    = 1000,
    parameter int NUM_DIGITS = 4,
    parameter int DATA_W     = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     i_data,
    input  logic                  i_valid,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    output logic                  o_busy,
    output logic                  o_overflow,
    output logic [NUM_DIGITS-1:0] fnd_com,
    output logic [7:0]            fnd_data
);

    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int PRE_W = $clog2(DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    conv_busy;
    logic                    conv_done;
    logic [4*NUM_DIGITS-1:0] conv_bcd;
    logic                    conv_ovf;

    logic [4*NUM_DIGITS-1:0] disp_q;
    logic                    ovf_q;
    logic [PRE_W-1:0]        pre_q;
    logic                    tick_q;
    logic [IDX_W-1:0]        idx_q;
    logic [NUM_DIGITS-1:0]   com_q;
    logic [7:0]              seg_q;
    logic [NUM_DIGITS-1:0]   com_d;
    logic [7:0]              seg_d;

    fnd_bin2bcd_seq #(
        .DATA_W     (DATA_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .reset   (reset),
        .start_i (i_valid & ~conv_busy),
        .data_i  (i_data),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd),
        .ovf_o   (conv_ovf)
    );

    // Latch the finished conversion as a whole so no digit is ever torn.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_q <= '0;
            ovf_q  <= 1'b0;
        end else if (conv_done) begin
            disp_q <= conv_bcd;
            ovf_q  <= conv_ovf;
        end
    end

    // Scan prescaler producing a one-cycle tick per digit slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= (pre_q == PRE_W'(DIV - 1));
            pre_q  <= (pre_q == PRE_W'(DIV - 1)) ? '0 : pre_q + PRE_W'(1);
        end
    end

    // Segment pattern for the digit about to be driven.
    always_comb begin
        logic [7:0] seg;
        logic       blank;
`ifdef LEADING_ZERO_BLANK_EN
        logic       upper_zero;
        upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(idx_q) && disp_q[4*i +: 4] != 4'd0) begin
                upper_zero = 1'b0;
            end
        end
        blank = (idx_q != '0) && upper_zero;
`else
        blank = 1'b0;
`endif
        if (ovf_q) begin
            seg = SEG_DASH;
        end else if (blank) begin
            seg = SEG_BLANK;
        end else begin
            seg = hex_to_seg(disp_q[4*idx_q +: 4]);
        end
        seg_d = {seg[7] & ~dp_mask[idx_q], seg[6:0]};
        com_d = ~(NUM_DIGITS'(1) << idx_q);
    end

    // Drive a new digit once per slot and advance the scan index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q <= '0;
            com_q <= '1;
            seg_q <= SEG_BLANK;
        end else if (tick_q) begin
            com_q <= com_d;
            seg_q <= seg_d;
            idx_q <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    assign o_busy     = conv_busy;
    assign o_overflow = ovf_q;
    assign fnd_com    = com_q;
    assign fnd_data   = seg_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Testbench for fnd_scan_controller: decimal-arithmetic reference model checked
// every cycle, plus directed scenarios with hand-computed segment values.
module tb_fnd_scan_controller;

    localparam int DATA_W = 14;
    localparam int ND     = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] i_data;
    logic              i_valid;
    logic [ND-1:0]     dp_mask;
    logic              busy_a, ovf_a, busy_b, ovf_b;
    logic [ND-1:0]     com_a, com_b;
    logic [7:0]        data_a, data_b;

    always #5 clk = ~clk;

    // Slot period 4 cycles
    fnd_scan_controller #(.CLK_HZ(40), .SCAN_HZ(10), .NUM_DIGITS(ND), .DATA_W(DATA_W)) dut_a (
        .clk(clk), .reset(reset), .i_data(i_data), .i_valid(i_valid), .dp_mask(dp_mask),
        .o_busy(busy_a), .o_overflow(ovf_a), .fnd_com(com_a), .fnd_data(data_a));

    // Minimum slot period: SCAN_HZ = CLK_HZ/2
    fnd_scan_controller #(.CLK_HZ(20), .SCAN_HZ(10), .NUM_DIGITS(ND), .DATA_W(DATA_W)) dut_b (
        .clk(clk), .reset(reset), .i_data(i_data), .i_valid(i_valid), .dp_mask(dp_mask),
        .o_busy(busy_b), .o_overflow(ovf_b), .fnd_com(com_b), .fnd_data(data_b));

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    localparam logic [7:0] SEG7 [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                         8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    function automatic int p10(input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [7:0] model_seg(input int value, input bit ovf, input int d, input logic dp);
        logic [7:0] s;
        if (ovf) s = 8'hBF;
        else begin
            s = SEG7[(value / p10(d)) % 10];
`ifdef LEADING_ZERO_BLANK_EN
            if (d > 0 && value < p10(d)) s = 8'hFF;
`endif
        end
        if (dp) s[7] = 1'b0;
        return s;
    endfunction

    function automatic int div_of(input int u);
        return (u == 0) ? 4 : 2;
    endfunction

    int         k;
    int         m_disp, m_pend, m_cnt;
    bit         m_ovf, m_busy;
    logic [3:0] e_com  [2];
    logic [7:0] e_data [2];

    // Model: edges counted since reset release give the digit slots; conversion
    // result becomes visible DATA_W+1 edges after the accepted load edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            k = 0; m_disp = 0; m_ovf = 0; m_busy = 0; m_cnt = 0; m_pend = 0;
            for (int u = 0; u < 2; u++) begin e_com[u] = 4'hF; e_data[u] = 8'hFF; end
        end else begin
            k++;
            for (int u = 0; u < 2; u++) begin
                if (k > div_of(u) && (k - 1) % div_of(u) == 0) begin
                    int slot;
                    slot = ((k - 1) / div_of(u) - 1) % ND;
                    e_com[u]  = ~(4'b1 << slot);
                    e_data[u] = model_seg(m_disp, m_ovf, slot, dp_mask[slot]);
                end
            end
            if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy = 0;
                    m_disp = m_pend;
                    m_ovf  = (m_pend >= p10(ND));
                end
            end else if (i_valid) begin
                m_busy = 1; m_cnt = DATA_W + 1; m_pend = int'(i_data);
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy_a", busy_a, m_busy);
            check("ovf_a",  ovf_a,  m_ovf);
            check("com_a",  com_a,  e_com[0]);
            check("data_a", data_a, e_data[0]);
            check("busy_b", busy_b, m_busy);
            check("ovf_b",  ovf_b,  m_ovf);
            check("com_b",  com_b,  e_com[1]);
            check("data_b", data_b, e_data[1]);
        end
    end

    // ---------------- directed stimulus ----------------
    logic [7:0] seen [4];

    task automatic load(input int v);
        @(negedge clk);
        i_data  = DATA_W'(v);
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy_a !== 1'b0 && t < 100) begin @(negedge clk); t++; end
        check("busy_timeout", busy_a, 1'b0);
    endtask

    task automatic grab_frame();
        for (int d = 0; d < 4; d++) seen[d] = 8'h00;
        repeat (40) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) if (com_a == ~(4'b1 << d)) seen[d] = data_a;
        end
    endtask

    task automatic expect_frame(input string name, input logic [7:0] d0, input logic [7:0] d1,
                                input logic [7:0] d2, input logic [7:0] d3);
        grab_frame();
        check({name, "_d0"}, seen[0], d0);
        check({name, "_d1"}, seen[1], d1);
        check({name, "_d2"}, seen[2], d2);
        check({name, "_d3"}, seen[3], d3);
    endtask

    initial begin
        int bcount;
        int t;
        reset = 1'b1; i_valid = 1'b0; i_data = '0; dp_mask = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_com",  com_a,  4'hF);
        check("rst_data", data_a, 8'hFF);
        check("rst_busy", busy_a, 1'b0);
        check("rst_ovf",  ovf_a,  1'b0);
        chk_en = 1'b1;
        @(posedge clk); #1 reset = 1'b0;

        // 1234: busy for 15 cycles, digits 4,3,2,1
        load(1234);
        bcount = 0;
        while (busy_a === 1'b1 && bcount < 100) begin bcount++; @(negedge clk); end
        check("busy_len", bcount, 15);
        expect_frame("v1234", 8'h99, 8'hB0, 8'hA4, 8'hF9);

        // overflow, then back to in-range
        load(10000); wait_idle();
        expect_frame("v10000", 8'hBF, 8'hBF, 8'hBF, 8'hBF);
        check("ovf_set", ovf_a, 1'b1);
        load(9999); wait_idle();
        expect_frame("v9999", 8'h90, 8'h90, 8'h90, 8'h90);
        check("ovf_clr", ovf_a, 1'b0);

        // decimal point on digit 1 with a single-digit value
        dp_mask = 4'b0010;
        load(7); wait_idle();
`ifdef LEADING_ZERO_BLANK_EN
        expect_frame("v7dp", 8'hF8, 8'h7F, 8'hFF, 8'hFF);
`else
        expect_frame("v7dp", 8'hF8, 8'h40, 8'hC0, 8'hC0);
`endif
        dp_mask = 4'b0000;

        // second load while busy is dropped
        load(1111);
        repeat (2) @(negedge clk);
        i_data = DATA_W'(5678); i_valid = 1'b1;
        @(negedge clk); i_valid = 1'b0;
        wait_idle();
        expect_frame("drop", 8'hF9, 8'hF9, 8'hF9, 8'hF9);

        // reset in the middle of a conversion
        load(4321);
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("abort_com",  com_a,  4'hF);
        check("abort_data", data_a, 8'hFF);
        check("abort_busy", busy_a, 1'b0);
        @(posedge clk); #1 reset = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        expect_frame("after_abort", 8'hC0, 8'hFF, 8'hFF, 8'hFF);
`else
        expect_frame("after_abort", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
`endif

        // minimum slot period: wrap 0111 -> 1110 with each digit held two cycles
        t = 0;
        while (com_b == 4'b0111 && t < 20) begin @(negedge clk); t++; end
        while (com_b != 4'b0111 && t < 40) begin @(negedge clk); t++; end
        check("scan_reach_d3", com_b, 4'b0111);
        @(negedge clk); check("scan_hold_d3", com_b, 4'b0111);
        @(negedge clk); check("scan_wrap_d0", com_b, 4'b1110);
        @(negedge clk); check("scan_hold_d0", com_b, 4'b1110);
        @(negedge clk); check("scan_next_d1", com_b, 4'b1101);

        repeat (4) @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
